// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-arbiter FSM state encoding.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first active request at or above ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // First pass covers ptr..NREQ-1, second pass wraps around to 0..ptr-1.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbitration of register-file write requesters with a registered write port,
// a timed register-file clear sequence and a saturating commit counter.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int CLR_CYCLES = 2,
    parameter bit DROP_R0    = 1'b1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*REG_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       clear_req,
    output logic                       write_cntrl,
    output logic [REG_ADDR_W-1:0]      writeaddr,
    output logic [REG_DATA_W-1:0]      write_data,
    output logic                       rf_clr,
    output logic [15:0]                wr_count,
    output rf_state_e                  dbg_state
);

    localparam int          PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  CLR_LOAD = 4'(CLR_CYCLES - 1);

    // Handshake: a transfer happens on a rising edge where req_valid[i] and req_ready[i]
    // are both high; req_ready is one-hot or zero and depends combinationally on req_valid.
    rf_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   run_en_q;
    logic                   wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]  waddr_q, waddr_d;
    logic [REG_DATA_W-1:0]  wdata_q, wdata_d;
    logic                   rf_clr_q, rf_clr_d;
    logic [15:0]            wr_count_q, wr_count_d;

    logic [NREQ-1:0]        gnt;
    logic                   fire;
    logic [REG_ADDR_W-1:0]  sel_addr;
    logic [REG_DATA_W-1:0]  sel_data;
    logic [PW-1:0]          ptr_nxt;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        ptr_nxt    = ptr_q;

        // run_en_q holds grants off until the first edge after reset release.
        req_ready  = (run_en_q && state_q == RUN && !clear_req) ? gnt : '0;
        fire       = |(req_valid & req_ready);

        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*REG_DATA_W +: REG_DATA_W];
                ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end

        if (fire) begin
            ptr_d = ptr_nxt;
            if (!(DROP_R0 && sel_addr == '0)) begin
                wr_en_d = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end

        // A clear request squashes the write that would commit on the same edge the clear starts.
        write_cntrl = wr_en_q && !clear_req;
        wr_count_d  = (write_cntrl && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;

        case (state_q)
            RUN: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = CLR_LOAD;
                end
            end
            CLEAR: begin
                if (clear_req) begin
                    cnt_d = CLR_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase

        rf_clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ptr_q      <= '0;
            run_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rf_clr_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            run_en_q   <= 1'b1;
            wr_en_q    <= wr_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rf_clr_q   <= rf_clr_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign writeaddr  = waddr_q;
    assign write_data = wdata_q;
    assign rf_clr     = rf_clr_q;
    assign wr_count   = wr_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations (NREQ=3, CLR_CYCLES=2).
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 3;

    logic                 clk;
    logic                 clr_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_addr;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 clear_req;
    logic                 write_cntrl;
    logic [4:0]           writeaddr;
    logic [31:0]          write_data;
    logic                 rf_clr;
    logic [15:0]          wr_count;
    rf_state_e            dbg_state;

    int n_total;
    int n_bad;

    rf_write_arbiter #(.NREQ(NREQ), .CLR_CYCLES(2), .DROP_R0(1'b1)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_req   (clear_req),
        .write_cntrl (write_cntrl),
        .writeaddr   (writeaddr),
        .write_data  (write_data),
        .rf_clr      (rf_clr),
        .wr_count    (wr_count),
        .dbg_state   (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        clr_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        clear_req = 1'b0;

        // reset values
        #3;
        check("rst_wc",    32'(write_cntrl), 32'd0);
        check("rst_waddr", 32'(writeaddr),   32'd0);
        check("rst_wdata", write_data,       32'd0);
        check("rst_rfclr", 32'(rf_clr),      32'd0);
        check("rst_cnt",   32'(wr_count),    32'd0);
        check("rst_state", 32'(dbg_state),   32'(RUN));
        req_valid = 3'b001;
        #1;
        check("rst_ready", 32'(req_ready),   32'd0);

        // release; no grant in the release cycle, first grant after next edge
        @(negedge clk);
        clr_n = 1'b1;
        set_req(0, 5'd25, 32'd25);
        #1;
        check("rel_ready_hold", 32'(req_ready), 32'd0);
        step();
        check("w25_ready", 32'(req_ready), 32'b001);
        step();
        req_valid = '0;
        check("w25_wc",    32'(write_cntrl), 32'd1);
        check("w25_addr",  32'(writeaddr),   32'd25);
        check("w25_data",  write_data,       32'd25);
        step();
        check("w25_cnt",   32'(wr_count),    32'd1);
        check("w25_wc_off",32'(write_cntrl), 32'd0);

        // requester 1 writes r0: handshake only (ptr is 1 here)
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("r0_ready", 32'(req_ready), 32'b010);
        step();
        req_valid = '0;
        check("r0_wc", 32'(write_cntrl), 32'd0);
        step();
        check("r0_cnt", 32'(wr_count), 32'd1);

        // requester 2 write moves ptr back to 0
        req_valid = 3'b100;
        set_req(2, 5'd4, 32'h44);
        #1;
        check("w4_ready", 32'(req_ready), 32'b100);
        step();
        req_valid = '0;
        check("w4_wc",   32'(write_cntrl), 32'd1);
        check("w4_addr", 32'(writeaddr),   32'd4);
        step();
        check("w4_cnt",  32'(wr_count),    32'd2);

        // round robin with all three valid
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
            if (k > 0) begin
                check($sformatf("rr_wc%0d", k),   32'(write_cntrl), 32'd1);
                check($sformatf("rr_addr%0d", k), 32'(writeaddr),   32'((k - 1) % 3 + 1));
            end
            step();
        end
        req_valid = '0;
        check("rr_last_addr", 32'(writeaddr), 32'd3);
        check("rr_last_data", write_data,     32'h102);
        step();
        check("rr_cnt", 32'(wr_count), 32'd8);

        // write to r28 then clear pulse: write squashed, 2 clear cycles
        req_valid = 3'b001;
        set_req(0, 5'd28, 32'h28);
        #1;
        check("w28_ready", 32'(req_ready), 32'b001);
        step();
        set_req(0, 5'd5, 32'h5);
        set_req(1, 5'd6, 32'h6);
        req_valid = 3'b011;
        clear_req = 1'b1;
        #1;
        check("sq_wc",    32'(write_cntrl), 32'd0);
        check("sq_ready", 32'(req_ready),   32'd0);
        step();
        clear_req = 1'b0;
        #1;
        check("clr1_rfclr", 32'(rf_clr),      32'd1);
        check("clr1_ready", 32'(req_ready),   32'd0);
        check("clr1_state", 32'(dbg_state),   32'(CLEAR));
        check("clr1_cnt",   32'(wr_count),    32'd8);
        step();
        check("clr2_rfclr", 32'(rf_clr),      32'd1);
        check("clr2_ready", 32'(req_ready),   32'd0);
        step();
        check("clr3_rfclr", 32'(rf_clr),      32'd0);
        check("clr3_ready", 32'(req_ready),   32'b010);
        check("clr3_cnt",   32'(wr_count),    32'd8);

        // reset in the middle of a clear
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("rc_rfclr", 32'(rf_clr), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        check("rc_rfclr_drop", 32'(rf_clr),      32'd0);
        check("rc_ready",      32'(req_ready),   32'd0);
        check("rc_wc",         32'(write_cntrl), 32'd0);
        check("rc_addr",       32'(writeaddr),   32'd0);
        check("rc_data",       write_data,       32'd0);
        check("rc_cnt",        32'(wr_count),    32'd0);
        check("rc_state",      32'(dbg_state),   32'(RUN));
        @(negedge clk);
        clr_n = 1'b1;
        step();
        check("rc_first_grant", 32'(req_ready), 32'b001);

        // saturation: 65535 writes fill the counter, two more must not wrap
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h7);
        repeat (65535) step();
        req_valid = '0;
        step();
        check("sat_full", 32'(wr_count), 32'hFFFF);
        req_valid = 3'b001;
        step();
        step();
        req_valid = '0;
        step();
        check("sat_hold",  32'(wr_count),    32'hFFFF);
        check("sat_wc_off",32'(write_cntrl), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of write requesters, legal range 2..8.
REQ-002 SHALL have parameter CLR_CYCLES, default 2: number of cycles register-file clear is held, legal range 1..15.
REQ-003 SHALL have parameter DROP_R0, default 1: when 1, writes to register 0 are accepted and discarded.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clr_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester write request.
REQ-007 SHALL have port req_addr, input, NREQ*5: per-requester destination register, packed, requester i at bits [5i+4:5i].
REQ-008 SHALL have port req_data, input, NREQ*32: per-requester write data, packed, requester i at bits [32i+31:32i].
REQ-009 SHALL have port req_ready, output, NREQ: one-hot or zero grant, combinational.
REQ-010 SHALL have port clear_req, input, 1: single-cycle pulse requesting a register-file clear.
REQ-011 SHALL have port write_cntrl, output, 1: register-file write enable.
REQ-012 SHALL have port writeaddr, output, 5: register-file write address.
REQ-013 SHALL have port write_data, output, 32: register-file write data.
REQ-014 SHALL have port rf_clr, output, 1: active-high register-file clear.
REQ-015 SHALL have port wr_count, output, 16: saturating count of committed writes.

Function
REQ-016 SHALL implement FSM states RUN and CLEAR.
REQ-017 RUN -> CLEAR on clear_req=1; CLEAR -> RUN after CLR_CYCLES cycles; clear_req seen while in CLEAR restarts the cycle count.
REQ-018 In RUN, the arbiter SHALL grant the first requester with req_valid=1, searching from pointer ptr upward modulo NREQ.
REQ-019 A transfer SHALL occur when req_valid[i]=1 and req_ready[i]=1 at a rising edge; ptr SHALL then become (i+1) mod NREQ.
REQ-020 ptr SHALL NOT change in a cycle with no transfer.
REQ-021 req_ready SHALL be all-zero in CLEAR, and in RUN on a cycle where clear_req=1.
REQ-022 The write path SHALL be registered: a transfer at edge N drives write_cntrl, writeaddr and write_data during cycle N+1, and the register file commits the write at edge N+1.
REQ-023 write_cntrl SHALL be 0 in any cycle without a preceding transfer; writeaddr and write_data SHALL then hold their last values.
REQ-024 With DROP_R0=1, a transfer to address 0 SHALL complete the handshake, keep write_cntrl=0, and leave wr_count unchanged.
REQ-025 rf_clr SHALL be 1 exactly during the CLR_CYCLES cycles spent in CLEAR.
REQ-026 On entry to CLEAR, a write already registered for the following cycle SHALL be squashed: write_cntrl=0 and wr_count not incremented.
REQ-027 wr_count SHALL increment by one per cycle with write_cntrl=1, saturate at 16'hFFFF, and NOT be reset by clear_req.
REQ-028 Requesters SHALL hold req_valid, req_addr and req_data stable until accepted; the block SHALL tolerate req_valid being dropped without acceptance.

Reset
REQ-029 While clr_n=0: state=RUN, ptr=0, write_cntrl=0, writeaddr=0, write_data=0, rf_clr=0, wr_count=0, req_ready=0.
REQ-030 Reset assertion SHALL take effect asynchronously; deassertion SHALL be synchronous to clk, with the first grant possible in the cycle after deassertion.
REQ-031 Reset mid-CLEAR SHALL abort the clear immediately and drop rf_clr.

Structure
REQ-032 The shared package rf_pkg SHALL hold REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, and the FSM state enumeration.
REQ-033 Round-robin selection SHALL live in a sub-module rr_arbiter (inputs: request vector and ptr; output: one-hot grant); FSM, output register and counter SHALL stay in the top module.

Verification
REQ-034 Reset, then req0 writes addr 25 data 25 -> write_cntrl=1, writeaddr=25, write_data=25 one cycle later; wr_count=1.
REQ-035 All three requesters held valid (addrs 1/2/3) for 6 cycles -> grant order 0,1,2,0,1,2, one write per cycle.
REQ-036 Requester 1 writes addr 0 data 32'hFFFF_FFFF -> handshake completes, write_cntrl=0, wr_count unchanged.
REQ-037 clear_req pulsed the cycle after an accepted write to addr 28 -> that write squashed; rf_clr=1 for exactly 2 cycles; req_ready=0 throughout; granting resumes in cycle 3.
REQ-038 clr_n pulled low during CLEAR with requests pending -> all outputs are at reset values within the same cycle; after release, req0 is granted first.
REQ-039 wr_count preloaded near saturation by 65535 writes, then 2 more writes -> wr_count=16'hFFFF.
